// File: rtl/skid_buffer_vrtl.sv
// Two-entry valid/ready skid buffer. deq_msg is always driven from the main
// register. The skid register absorbs the one extra message that can arrive
// in the cycle after the consumer stalls. Both ready and valid come straight
// from state, so no combinational path runs from enq_* to deq_* or from
// deq_rdy to enq_rdy.
//
// state | meaning
// EMPTY | nothing held; deq_val = 0
// ONE   | main holds the oldest message
// TWO   | main holds the oldest message, skid holds the next; enq_rdy = 0
module skid_buffer_vrtl #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enq_val,
   output logic               enq_rdy,
   input  logic [p_nbits-1:0] enq_msg,
   output logic               deq_val,
   input  logic               deq_rdy,
   output logic [p_nbits-1:0] deq_msg
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [p_nbits-1:0] main_q;
   logic [p_nbits-1:0] main_nxt;
   logic [p_nbits-1:0] skid_q;
   logic [p_nbits-1:0] skid_nxt;
   logic               enq_fire;
   logic               deq_fire;

   // Handshake outputs decode state only. enq_rdy is also gated by reset,
   // because state already reads EMPTY while reset is held.
   always_comb begin
      deq_val  = (state != EMPTY);
      enq_rdy  = (state != TWO) && reset;
      deq_msg  = main_q;
      enq_fire = enq_val && enq_rdy;
      deq_fire = deq_val && deq_rdy;
   end

   // State register and storage; reset clears everything immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state  <= state_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
      end
   end

   // Next-state logic and storage updates.
   always_comb begin
      state_nxt = state;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      unique case (state)
         EMPTY: begin
            if (enq_fire) begin
               state_nxt = ONE;
               main_nxt  = enq_msg;
            end
         end
         ONE: begin
            if (enq_fire && deq_fire) begin
               main_nxt = enq_msg;
            end else if (enq_fire) begin
               state_nxt = TWO;
               skid_nxt  = enq_msg;
            end else if (deq_fire) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            // enq_rdy is low here, so only a dequeue can change anything.
            // The skid entry moves into main without a bubble.
            if (deq_fire) begin
               state_nxt = ONE;
               main_nxt  = skid_q;
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

endmodule

// File: tb/tb_skid_buffer_vrtl.sv
// Scoreboard bench for skid_buffer_vrtl. The stimulus process pushes each
// message it expects to come out. The monitor pops and compares on every
// dequeue it observes at the falling edge.
module tb_skid_buffer_vrtl;

   localparam int NB = 32;

   logic          clk;
   logic          reset;
   logic          enq_val;
   logic          enq_rdy;
   logic [NB-1:0] enq_msg;
   logic          deq_val;
   logic          deq_rdy;
   logic [NB-1:0] deq_msg;

   int            n_vec;
   int            n_err;
   logic [NB-1:0] exp_q[$];

   skid_buffer_vrtl #(.p_nbits(NB)) dut (
      .clk     (clk),
      .reset   (reset),
      .enq_val (enq_val),
      .enq_rdy (enq_rdy),
      .enq_msg (enq_msg),
      .deq_val (deq_val),
      .deq_rdy (deq_rdy),
      .deq_msg (deq_msg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: each dequeue must match the oldest expected message.
   always @(negedge clk) begin
      if (deq_val === 1'b1 && deq_rdy === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_deq: got %h expected no dequeue at %0t", deq_msg, $time);
         end else begin
            logic [NB-1:0] e;
            e = exp_q.pop_front();
            if (deq_msg !== e) begin
               n_err++;
               $display("FAIL deq_msg: got %h expected %h at %0t", deq_msg, e, $time);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b0;
      enq_val = 1'b1;
      enq_msg = 32'hDEADBEEF;
      deq_rdy = 1'b0;

      // Reset: inputs are ignored while reset is held.
      repeat (3) tick();
      chk("rst_enq_rdy", enq_rdy, 0);
      chk("rst_deq_val", deq_val, 0);
      chk("rst_deq_msg", deq_msg, 0);
      reset = 1'b1;
      #1;
      chk("post_rst_enq_rdy", enq_rdy, 1);
      chk("post_rst_deq_val", deq_val, 0);
      exp_q.push_back(32'hDEADBEEF);
      tick();
      chk("first_deq_val", deq_val, 1);
      chk("first_deq_msg", deq_msg, 32'hDEADBEEF);
      enq_val = 1'b0;
      deq_rdy = 1'b1;
      tick();
      chk("first_empty", deq_val, 0);

      // Streaming: one message per cycle with no stall.
      for (int i = 1; i <= 4; i++) begin
         enq_val = 1'b1;
         enq_msg = NB'(i);
         exp_q.push_back(NB'(i));
         chk("stream_enq_rdy", enq_rdy, 1);
         tick();
         chk("stream_deq_val", deq_val, 1);
      end
      enq_val = 1'b0;
      tick();
      chk("stream_empty", deq_val, 0);
      chk("stream_sb_empty", NB'(exp_q.size()), 0);

      // Stall/fill: the buffer accepts 0xA and 0xB, then refuses 0xC.
      deq_rdy = 1'b0;
      enq_val = 1'b1;
      enq_msg = 32'hA;
      exp_q.push_back(32'hA);
      chk("fill_rdy_a", enq_rdy, 1);
      tick();
      enq_msg = 32'hB;
      exp_q.push_back(32'hB);
      chk("fill_rdy_b", enq_rdy, 1);
      tick();
      enq_msg = 32'hC;
      chk("fill_rdy_c", enq_rdy, 0);
      tick();
      chk("fill_hold_msg", deq_msg, 32'hA);
      chk("fill_hold_val", deq_val, 1);
      chk("fill_hold_rdy", enq_rdy, 0);
      tick();
      chk("fill_stable_msg", deq_msg, 32'hA);

      // Drain: 0xA, 0xB and 0xC leave on consecutive cycles.
      deq_rdy = 1'b1;
      exp_q.push_back(32'hC);
      tick();
      chk("drain_recover_rdy", enq_rdy, 1);
      chk("drain_msg_b", deq_msg, 32'hB);
      tick();
      enq_val = 1'b0;
      chk("drain_msg_c", deq_msg, 32'hC);
      tick();
      chk("drain_empty", deq_val, 0);

      // Simultaneous enq and deq while in ONE.
      deq_rdy = 1'b0;
      enq_val = 1'b1;
      enq_msg = 32'h5;
      exp_q.push_back(32'h5);
      tick();
      enq_msg = 32'h6;
      exp_q.push_back(32'h6);
      deq_rdy = 1'b1;
      tick();
      enq_val = 1'b0;
      deq_rdy = 1'b0;
      chk("simul_msg", deq_msg, 32'h6);
      chk("simul_val", deq_val, 1);
      chk("simul_rdy", enq_rdy, 1);
      deq_rdy = 1'b1;
      tick();
      chk("simul_empty", deq_val, 0);

      // Async reset mid-operation: the held 0xA and 0xB are discarded.
      deq_rdy = 1'b0;
      enq_val = 1'b1;
      enq_msg = 32'hA;
      tick();
      enq_msg = 32'hB;
      tick();
      enq_val = 1'b0;
      chk("two_rdy", enq_rdy, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("async_deq_val", deq_val, 0);
      chk("async_enq_rdy", enq_rdy, 0);
      chk("async_deq_msg", deq_msg, 0);
      deq_rdy = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      #1;
      chk("rel_deq_val", deq_val, 0);
      chk("rel_enq_rdy", enq_rdy, 1);
      repeat (4) tick();
      chk("rel_still_empty", deq_val, 0);
      chk("final_sb_empty", NB'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
